// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, rotation schedule, state encodings.
// Table entries use DES numbering: entry value 1 selects the MSB of the source vector.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {
    KS_EMPTY  = 2'd0,
    KS_ACTIVE = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_e;

  function automatic logic [HALF_W-1:0] rot_l(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rot_r(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Strobe/subkey bundle between the DES control FSM (master) and the key schedule (slave).
interface des_key_schedule_if;
  import des_pkg::*;

  logic [KEY_W-1:0]    key_in;
  logic                mode;
  logic                load_input;
  logic                key_shift_en;
  logic                key_perm_en;
  logic [SUBKEY_W-1:0] subkey;
  logic                subkey_valid;
  logic [4:0]          shift_cnt;
  logic                sched_done;
  logic                seq_err;
  logic                parity_err;

  modport master (
    output key_in, mode, load_input, key_shift_en, key_perm_en,
    input  subkey, subkey_valid, shift_cnt, sched_done, seq_err, parity_err
  );

  modport slave (
    input  key_in, mode, load_input, key_shift_en, key_perm_en,
    output subkey, subkey_valid, shift_cnt, sched_done, seq_err, parity_err
  );
endinterface

// File: rtl/des_pc2.sv
// Combinational PC-2 compression: 56-bit {C,D} to 48-bit round key (bit 47 = output bit 1).
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey_o[SUBKEY_W-1-i] = cd_i[2*HALF_W-PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 load, per-round C/D rotation, registered PC-2 subkey with valid pulse.
// Optional DES_KEY_PARITY_CHECK_EN adds an odd-parity check of key_in on load.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic               clk,
  input  logic               reset,
  des_key_schedule_if.slave  bus
);

  ks_state_e           state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic                mode_q, mode_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [SUBKEY_W-1:0] subkey_q, subkey_d;
  logic                valid_q, valid_d;
  logic                seq_err_q, seq_err_d;

  logic [2*HALF_W-1:0] pc1_cd;
  logic [SUBKEY_W-1:0] pc2_out;
  logic [3:0]          sched_idx;
  logic                two_step;

  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 2*HALF_W; i++) begin
      pc1_cd[2*HALF_W-1-i] = bus.key_in[KEY_W-PC1[i]];
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_out)
  );

  // Decrypt walks the schedule backwards, so round k uses the amount of round 16-k.
  always_comb begin
    sched_idx = mode_q ? 4'(5'd16 - cnt_q) : cnt_q[3:0];
    two_step  = (SHIFT_SCHED[sched_idx] == 2);
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    subkey_d  = subkey_q;
    valid_d   = 1'b0;
    seq_err_d = seq_err_q;

    if (bus.key_perm_en) begin
      subkey_d = pc2_out;
      valid_d  = 1'b1;
      if (state_q == KS_EMPTY) seq_err_d = 1'b1;
    end

    if (bus.load_input) begin
      c_d       = pc1_cd[2*HALF_W-1:HALF_W];
      d_d       = pc1_cd[HALF_W-1:0];
      mode_d    = bus.mode;
      cnt_d     = '0;
      seq_err_d = 1'b0;
      state_d   = KS_ACTIVE;
    end else if (bus.key_shift_en) begin
      if (state_q == KS_ACTIVE) begin
        if (!mode_q) begin
          c_d = rot_l(c_q, two_step);
          d_d = rot_l(d_q, two_step);
        end else if (cnt_q != '0) begin
          // First decrypt shift leaves C0/D0 in place: it already equals C16/D16.
          c_d = rot_r(c_q, two_step);
          d_d = rot_r(d_q, two_step);
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_d == 5'(NUM_ROUNDS)) state_d = KS_DONE;
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= KS_EMPTY;
      c_q       <= '0;
      d_q       <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      subkey_q  <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      subkey_q  <= subkey_d;
      valid_q   <= valid_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_bad;
  logic parity_err_q, parity_err_d;

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      par_bad = par_bad | ~(^bus.key_in[8*b +: 8]);
    end
    parity_err_d = bus.load_input ? par_bad : parity_err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`else
  // Parity bits are dropped by PC-1; fold them so they are not flagged as dangling.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                                bus.key_in[24], bus.key_in[16], bus.key_in[8], bus.key_in[0]};
  assign bus.parity_err = 1'b0;
`endif

  assign bus.subkey       = subkey_q;
  assign bus.subkey_valid = valid_q;
  assign bus.shift_cnt    = cnt_q;
  assign bus.sched_done   = (state_q == KS_DONE);
  assign bus.seq_err      = seq_err_q;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Key-schedule responder for the DES control FSM.
- Consumes the FSM's load_input, key_shift_en and key_perm_en strobes; holds the 28-bit C/D halves; applies the per-round rotation (left for encrypt, right for decrypt).
- Delivers a registered 48-bit PC-2 subkey with a one-cycle valid pulse to the round datapath.

Parameters:
- NUM_ROUNDS, 16, number of shift strobes accepted after a key load before saturating.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- key_in  in  64  DES key, bit 63 = DES bit 1; parity bits ignored by PC-1
- mode  in  1  0 encrypt, 1 decrypt; sampled only with load_input
- load_input  in  1  load key_in through PC-1, latch mode, clear counter
- key_shift_en  in  1  rotate C/D by this round's amount
- key_perm_en  in  1  compute PC-2 of current C/D into subkey
- subkey  out  48  registered round key, bit 47 = PC-2 output bit 1
- subkey_valid  out  1  one-cycle pulse, cycle after key_perm_en
- shift_cnt  out  5  shifts applied since last load, 0..16
- sched_done  out  1  high while shift_cnt == NUM_ROUNDS
- seq_err  out  1  sticky; cleared by load_input or reset
- parity_err  out  1  see Optional Feature

Behaviour:
- Reset (asynchronous, immediate):
  - C, D, subkey, shift_cnt = 0
  - subkey_valid, sched_done, seq_err, parity_err = 0
  - latched mode = 0; state = EMPTY
- States: EMPTY (no key loaded), ACTIVE (shift_cnt < 16), DONE (shift_cnt == 16).
  - Any state with load_input -> ACTIVE.
  - ACTIVE with the 16th accepted shift -> DONE.
  - DONE stays in DONE until load_input.
- Load:
  - load_input at edge n: {C,D} = PC-1(key_in), mode latched, shift_cnt = 0, seq_err = 0; all visible at n+1.
  - Takes priority over a same-cycle key_shift_en, which is dropped and not flagged.
- Shift amount s[r], r = 0..15: 1 for r in {0,1,8,15}, otherwise 2.
- Encrypt shift:
  - key_shift_en with shift_cnt = k: C and D each rotate left by s[k]; shift_cnt = k+1.
  - A 2-position rotate completes in one cycle.
- Decrypt shift:
  - k = 0: no rotation, shift_cnt = 1 (K16 = PC-2(C0,D0)).
  - k = 1..15: C and D each rotate right by s[16-k]; shift_cnt = k+1.
- Effect of the control FSM sequence: KEY_SHIFT then KEY_PERM in consecutive cycles.
  - Round r gets K(r+1) when encrypting and K(16-r) when decrypting.
- Permutation:
  - key_perm_en at edge n: subkey = PC-2 of the C/D value present before edge n; subkey_valid = 1 during n+1 only.
  - With key_perm_en and key_shift_en in the same cycle, the pre-shift C/D is used.
  - key_perm_en in EMPTY: subkey = PC-2(0) = 0, valid still pulses, seq_err set.
- key_shift_en in EMPTY or DONE: ignored (C, D, shift_cnt unchanged), seq_err set.
- Reaching DONE in encrypt mode leaves C/D equal to the post-PC-1 value (28 total rotations), so a fresh load is not required to reuse the key.
- Back-to-back key_perm_en produces consecutive valid pulses with the same subkey.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - On load_input, parity_err = 1 if any key_in byte has even parity (DES odd-parity rule).
  - parity_err is registered with the load and cleared by the next clean load or by reset.
  - The key is still loaded.
- Undefined: parity_err is constant 0 and no parity logic is synthesized.

Decomposition:
- Package des_pkg holds:
  - the PC1 table (56 entries) and PC2 table (48 entries) as constant index arrays;
  - the 16-entry SHIFT_SCHED constant;
  - state encodings KS_EMPTY, KS_ACTIVE, KS_DONE;
  - width constants (KEY_W = 64, HALF_W = 28, SUBKEY_W = 48).
- One combinational sub-module, des_pc2 (56 -> 48 permutation). It is reused by the round datapath's test model.
- PC-1 stays inline, since it is used only at load.

Test Plan:
- Encrypt K1: key 133457799BBCDFF1, mode 0, load; check C0 = F0CCAAF, D0 = 556678F. Then shift and perm -> subkey 1B02EFFC7072, valid one cycle.
- Full encrypt schedule: same key, 16 shift/perm pairs. K2 = 79AED9DBC9E5 and K16 = CB3D8B0E17F5; sched_done = 1 after the 16th shift; C/D back to F0CCAAF/556678F.
- Decrypt: same key, mode 1. First pair -> CB3D8B0E17F5; 16th pair -> 1B02EFFC7072; all 16 subkeys equal the encrypt list reversed.
- Sequence errors:
  - 17th shift -> ignored, shift_cnt stays 16, seq_err = 1.
  - Shift after reset with no load -> seq_err = 1, C/D stay 0.
  - A following load clears seq_err.
- Simultaneous strobes:
  - load_input with key_shift_en -> shift_cnt = 0, C/D = PC-1 value.
  - key_shift_en with key_perm_en at k = 0 (encrypt) -> subkey = PC-2(C0,D0) = CB3D8B0E17F5; next perm gives 1B02EFFC7072.
- Reset mid-schedule at shift_cnt = 7 -> all outputs 0 immediately (asynchronous). With DES_KEY_PARITY_CHECK_EN, load 133457799BBCDFF0 -> parity_err = 1.
